// File: rtl/log_afpm_stream.sv
// Streaming Mitchell-log approximate FP multiplier: byte-serial operand load, one compute
// cycle, byte-serial result with backpressure. Optional macro LOG_AFPM_ERR_COMP_EN adds mean-error compensation.
module log_afpm_stream #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    parameter int unsigned BUS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] a_byte,
    input  logic [BUS_W-1:0] b_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_byte,
    output logic             out_last,
    output logic [4:0]       out_flags
);

    localparam int unsigned W       = 1 + EXP_W + MAN_W;
    localparam int unsigned BEATS   = W / BUS_W;
    localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned EW2     = EXP_W + 2;
    localparam int unsigned MW1     = MAN_W + 1;
    localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {LOAD, COMP, SEND} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     result_reg;

    logic             sign_c;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;
    logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [MW1-1:0]   sum_c;
    logic             carry_c;
    logic [MAN_W-1:0] frac_c;
    logic [EW2-1:0]   e_u;
    logic signed [EW2-1:0] e_s;
    logic [W-1:0]     res_c;
    logic [4:0]       flags_c;

    assign sign_c  = a_reg[W-1] ^ b_reg[W-1];
    assign exp_a   = a_reg[W-2 -: EXP_W];
    assign exp_b   = b_reg[W-2 -: EXP_W];
    assign man_a   = a_reg[MAN_W-1:0];
    assign man_b   = b_reg[MAN_W-1:0];
    assign nan_a   = (exp_a == '1) && (man_a != '0);
    assign nan_b   = (exp_b == '1) && (man_b != '0);
    assign inf_a   = (exp_a == '1) && (man_a == '0);
    assign inf_b   = (exp_b == '1) && (man_b == '0);
    assign zero_a  = (exp_a == '0);
    assign zero_b  = (exp_b == '0);

    // Log-domain add: mantissa sum, carry bumps the exponent
    assign sum_c   = MW1'(man_a) + MW1'(man_b);
    assign carry_c = sum_c[MAN_W];
    assign e_u     = EW2'(exp_a) + EW2'(exp_b) + EW2'(carry_c) - EW2'(BIAS);
    assign e_s     = e_u;

`ifdef LOG_AFPM_ERR_COMP_EN
    logic [MW1-1:0] comp_c;
    assign comp_c = MW1'(sum_c[MAN_W-1:0]) + MW1'(1 << (MAN_W - 4));
    assign frac_c = carry_c ? sum_c[MAN_W-1:0]
                            : (comp_c[MAN_W] ? '1 : comp_c[MAN_W-1:0]);
`else
    assign frac_c = sum_c[MAN_W-1:0];
`endif

    // Exception priority: nan, inf, zero, overflow, underflow
    always_comb begin
        res_c   = {sign_c, e_u[EXP_W-1:0], frac_c};
        flags_c = 5'b00000;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            res_c   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags_c = 5'b10000;
        end else if (inf_a || inf_b) begin
            res_c   = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c = 5'b01000;
        end else if (zero_a || zero_b) begin
            res_c   = {sign_c, {(W-1){1'b0}}};
            flags_c = 5'b00100;
        end else if (e_s >= $signed(EW2'(EXP_MAX))) begin
            res_c   = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c = 5'b01010;
        end else if (e_s <= $signed(EW2'(0))) begin
            res_c   = {sign_c, {(W-1){1'b0}}};
            flags_c = 5'b00101;
        end
    end

    // Operands shift in from the top so the first (LSB) beat ends up at bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            cnt        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_byte   <= '0;
            out_last   <= 1'b0;
            out_flags  <= '0;
        end else if (en) begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        a_reg <= W'({a_byte, a_reg} >> BUS_W);
                        b_reg <= W'({b_byte, b_reg} >> BUS_W);
                        if (cnt == CNT_W'(BEATS - 1)) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= COMP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                COMP: begin
                    result_reg <= res_c;
                    out_flags  <= flags_c;
                    cnt        <= '0;
                    state      <= SEND;
                end
                SEND: begin
                    if (!out_valid) begin
                        // Entry cycle presents beat 0
                        out_valid  <= 1'b1;
                        out_byte   <= result_reg[BUS_W-1:0];
                        result_reg <= W'(result_reg >> BUS_W);
                        out_last   <= (BEATS == 1);
                    end else if (out_ready) begin
                        if (cnt == CNT_W'(BEATS - 1)) begin
                            out_valid <= 1'b0;
                            out_byte  <= '0;
                            out_last  <= 1'b0;
                            out_flags <= '0;
                            in_ready  <= 1'b1;
                            cnt       <= '0;
                            state     <= LOAD;
                        end else begin
                            out_byte   <= result_reg[BUS_W-1:0];
                            result_reg <= W'(result_reg >> BUS_W);
                            out_last   <= (cnt == CNT_W'(BEATS - 2));
                            cnt        <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_log_afpm_stream.sv
// Bench for log_afpm_stream: directed operands, integer-arithmetic reference model,
// per-cycle output compare against a queue of expected results.
module tb_log_afpm_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic [4:0] out_flags;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int idx = 0;
    logic [20:0] exp_q[$];

`ifdef LOG_AFPM_ERR_COMP_EN
    localparam logic [15:0] NOM_RES = 16'h54DF;
`else
    localparam logic [15:0] NOM_RES = 16'h549F;
`endif
    localparam logic [7:0] NOM_LO = NOM_RES[7:0];

    log_afpm_stream dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_byte(a_byte), .b_byte(b_byte),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Half-precision-style reference: {flags[4:0], result[15:0]}
    function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, s, c, frac, e;
        logic sg;
        bit na, nb, ia, ib, za, zb;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = int'(a[9:0]);   mb = int'(b[9:0]);
        sg = a[15] ^ b[15];
        na = (ea == 31) && (ma != 0); nb = (eb == 31) && (mb != 0);
        ia = (ea == 31) && (ma == 0); ib = (eb == 31) && (mb == 0);
        za = (ea == 0);               zb = (eb == 0);
        if (na || nb || (ia && zb) || (ib && za)) return {5'h10, 16'h7E00};
        if (ia || ib) return {5'h08, sg, 15'h7C00};
        if (za || zb) return {5'h04, sg, 15'h0000};
        s = ma + mb;
        c = (s >= 1024) ? 1 : 0;
        frac = s % 1024;
`ifdef LOG_AFPM_ERR_COMP_EN
        if (c == 0) begin
            frac = frac + 64;
            if (frac > 1023) frac = 1023;
        end
`endif
        e = ea + eb - 15 + c;
        if (e >= 31) return {5'h0A, sg, 15'h7C00};
        if (e <= 0)  return {5'h05, sg, 15'h0000};
        return {5'h00, sg, 5'(e), 10'(frac)};
    endfunction

    // Output monitor: checks every cycle at the falling edge
    initial begin
        logic [20:0] cur;
        logic [15:0] res;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out", 32'(out_valid), 32'd0);
                    end else begin
                        cur = exp_q[0];
                        res = cur[15:0] >> (8 * idx);
                        chk("out_byte", 32'(out_byte), 32'(res[7:0]));
                        chk("out_last", 32'(out_last), 32'(idx == 1));
                        chk("out_flags", 32'(out_flags), 32'(cur[20:16]));
                        chk("in_ready_busy", 32'(in_ready), 32'd0);
                        if (en && out_ready) begin
                            if (idx == 1) begin
                                cur = exp_q.pop_front();
                                idx = 0;
                                done_cnt++;
                            end else begin
                                idx++;
                            end
                        end
                    end
                end else begin
                    chk("idle_byte", 32'(out_byte), 32'd0);
                    chk("idle_last", 32'(out_last), 32'd0);
                end
            end
        end
    end

    // Present one beat from posedge+1 until accepted
    task automatic put_beat(input logic [7:0] a, input logic [7:0] b);
        bit ok;
        int t;
        t = 0;
        a_byte = a; b_byte = b; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = in_ready && en;
            @(posedge clk); #1;
            if (ok || t > 50) break;
            t++;
        end
        chk("beat_accept", 32'(ok), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tx_done", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit lat);
        int n;
        int d0;
        d0 = done_cnt;
        out_ready = 1'b1;
        put_beat(a[7:0], b[7:0]);
        exp_q.push_back(model(a, b));
        put_beat(a[15:8], b[15:8]);
        if (lat) begin
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("latency", 32'(n), 32'd2);
        end
        wait_done(d0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_byte = '0; b_byte = '0;

        // Pin the reference model with hand-computed values
        chk("model_nominal", 32'(model(16'h4871, 16'h482E)), 32'({5'h00, NOM_RES}));
        chk("model_carry",   32'(model(16'h3E00, 16'h3E00)), 32'({5'h00, 16'h4000}));
        chk("model_infzero", 32'(model(16'h7C00, 16'h0000)), 32'({5'h10, 16'h7E00}));
        chk("model_ovf",     32'(model(16'h7BFF, 16'h7BFF)), 32'({5'h0A, 16'h7C00}));
        chk("model_neginf",  32'(model(16'hFC00, 16'h3C00)), 32'({5'h08, 16'hFC00}));
        chk("model_udf",     32'(model(16'h0400, 16'h0400)), 32'({5'h05, 16'h0000}));
        chk("model_udf_neg", 32'(model(16'h8400, 16'h0400)), 32'({5'h05, 16'h8000}));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_byte",  32'(out_byte), 32'd0);
        chk("rst_out_last",  32'(out_last), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h4871, 16'h482E, 1'b1);
        run_op(16'h3E00, 16'h3E00, 1'b1);
        run_op(16'h7C00, 16'h0000, 1'b0);
        run_op(16'h7BFF, 16'h7BFF, 1'b0);
        run_op(16'hFC00, 16'h3C00, 1'b0);
        run_op(16'h0400, 16'h0400, 1'b0);
        run_op(16'h8400, 16'h0400, 1'b0);
        run_op(16'h7C01, 16'h3C00, 1'b0);
        run_op(16'h3C00, 16'hBC00, 1'b0);

        // Input gap, output stall, and clock-enable hold during send
        d0 = done_cnt;
        out_ready = 1'b0;
        put_beat(8'h71, 8'h2E);
        repeat (2) begin @(posedge clk); #1; end
        exp_q.push_back(model(16'h4871, 16'h482E));
        put_beat(8'h48, 8'h48);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        repeat (3) begin
            chk("bp_hold_byte", 32'(out_byte), 32'(NOM_LO));
            chk("bp_in_ready",  32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("en_hold_byte",  32'(out_byte), 32'h54);
            chk("en_hold_valid", 32'(out_valid), 32'd1);
            chk("en_hold_last",  32'(out_last), 32'd1);
        end
        en = 1'b1;
        wait_done(d0);

        // Reset after the first beat abandons the partial load
        put_beat(8'h71, 8'h2E);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready",  32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(16'h3E00, 16'h3E00, 1'b1);

        repeat (4) begin @(posedge clk); #1; end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/log_afpm_stream.md
Name: log_afpm_stream

Overview:
- Parametrised successor to the two-beat logarithmic (Mitchell) approximate FP multiplier.
- Takes two IEEE-style floating-point operands of configurable exponent/mantissa width, loaded least-significant byte first over a narrow bus under a valid/ready handshake.
- Computes the approximate product by adding log-domain mantissas, then streams the result back over the same-width bus with backpressure and exception flags.
- Sits behind the TinyTapeout pin wrapper: a_byte/b_byte map to ui_in/uio_in, out_byte maps to uo_out.

Parameters:
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 10, stored mantissa field width.
- BUS_W, 8, beat width. W = 1+EXP_W+MAN_W must be a multiple of BUS_W; BEATS = W/BUS_W, minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  clock enable; when low, all state holds.
- in_valid  in  1  a_byte/b_byte carry a beat.
- in_ready  out  1  block accepts a beat.
- a_byte  in  BUS_W  operand A beat, LSB beat first.
- b_byte  in  BUS_W  operand B beat, LSB beat first.
- out_valid  out  1  out_byte holds a result beat.
- out_ready  in  1  consumer accepts a beat.
- out_byte  out  BUS_W  result beat, LSB beat first.
- out_last  out  1  marks the final result beat.
- out_flags  out  5  {nan, inf, zero, ovf, udf}; valid whenever out_valid=1.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state LOAD, beat counter 0, in_ready=1, out_valid=0, out_byte=0, out_last=0, out_flags=0, operand and result registers 0.
- States:
  - LOAD: in_ready=1. Each edge with en&in_valid shifts the beat into the A/B registers at beat index cnt, then cnt++. An in_valid gap holds cnt. On the edge accepting beat BEATS-1, go to COMP.
  - COMP: one cycle; in_ready=0. Register result and flags, cnt=0, then go to SEND.
  - SEND: out_valid=1 and out_byte = result beat cnt. out_last=1 when cnt=BEATS-1. out_byte, out_last and out_flags are held stable while out_ready=0. Each edge with en&out_ready advances cnt. After the last beat is accepted: out_valid=0, out_byte=0, return to LOAD. A new operand can load the next cycle.
- Latency: out_valid rises on the 2nd en-qualified edge after the edge that accepted the last input beat.
- Arithmetic (truncating, no rounding):
  - s = mA + mB, MAN_W+1 bits; carry c = s[MAN_W].
  - frac = s[MAN_W-1:0].
  - e = eA + eB - bias + c, computed signed at EXP_W+2 bits.
  - Sign = sA^sB.
- Exception priority:
  1. NaN if either operand is NaN, or inf×zero. Output sign 0, exponent all ones, mantissa MSB=1; flag nan.
  2. inf if either operand is inf. Output signed inf; flag inf.
  3. zero if either exponent field is 0 (subnormals flushed). Output signed zero; flag zero.
  4. e ≥ 2^EXP_W-1: output signed inf; flags ovf, inf.
  5. e ≤ 0: output signed zero; flags udf, zero.
- en low: freezes the FSM, counters and outputs; handshakes are ignored.
- rst asserted mid-load or mid-send: abandons the operation immediately. Partial beats are discarded; restart is at beat 0.

Optional Feature:
- Macro: LOG_AFPM_ERR_COMP_EN.
- Defined: when c=0, frac is replaced by frac + 2^(MAN_W-4), saturating at all-ones. This reduces Mitchell's mean error. When c=1, no change.
- Undefined: pure Mitchell truncation as above. Latency, ports and flags are identical in both cases.

Test Plan:
- Nominal: A=0x4871, B=0x482E in 2 beats (0x71/0x2E, then 0x48/0x48), out_ready=1.
  - Without the macro: out beats 0x9F then 0x54 (out_last on 2nd); flags 0; latency 2 edges.
  - With the macro: beats 0xDF, 0x54.
- Carry: 0x3E00 × 0x3E00 → 0x4000 (beats 0x00, 0x40); flags 0; same result with the macro.
- Specials:
  - 0x7C00 × 0x0000 → 0x7E00, flags=nan.
  - 0x7BFF × 0x7BFF → 0x7C00, flags ovf|inf.
  - 0xFC00 × 0x3C00 → 0xFC00, flags inf.
- Underflow and sign:
  - 0x0400 × 0x0400 → 0x0000, flags udf|zero.
  - 0x8400 × 0x0400 → 0x8000.
- Backpressure: nominal operands with a 2-cycle in_valid gap between beats, and out_ready low for 3 cycles in SEND.
  - out_byte holds 0x9F and in_ready=0 throughout.
  - Result is unchanged; en low for 2 cycles mid-send also holds all outputs.
- Reset mid-op:
  - Pulse rst after beat 0 is accepted → in_ready=1, out_valid=0 immediately.
  - A fresh 2-beat load of 0x3E00×0x3E00 then yields 0x4000.
